bp_me_burst_arbiter: RTL

Round-robin arbiter that merges `num_src_p` BedRock Burst sources onto one BedRock Burst output. Sources are typically stream-to-burst converters feeding a shared memory or network port. Arbitration happens on header beats. A granted data-carrying message holds the output until its last data beat is consumed, so header/data beats of different messages never interleave.

---
 rtl/bp_me_burst_arbiter_pkg.sv | 13 +
 rtl/bp_me_burst_arbiter_rr.sv | 36 +++
 rtl/bp_me_burst_arbiter.sv | 73 +++++++
 3 files changed

// File: rtl/bp_me_burst_arbiter_pkg.sv
// bp_me_burst_arbiter_pkg: BedRock burst header sizing shared by the burst arbiter files
package bp_me_burst_arbiter_pkg;
  localparam int msg_type_width_gp = 4;
  localparam int subop_width_gp = 4;
  localparam int size_width_gp = 3;
  localparam int paddr_width_gp = 40;
  function automatic int bedrock_header_width(input int paddr_w, input int payload_w);
    return msg_type_width_gp + subop_width_gp + paddr_w + size_width_gp + payload_w;
  endfunction
  function automatic int safe_clog2(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bp_me_burst_arbiter_rr.sv
// bp_me_burst_arbiter_rr: round-robin grant; priority starts just after the last accepted source
module bp_me_burst_arbiter_rr
  import bp_me_burst_arbiter_pkg::*;
#(
  parameter int num_src_p = 2,
  localparam int id_w = safe_clog2(num_src_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [num_src_p-1:0] reqs_i,
  input  logic                 yumi_i,
  output logic [num_src_p-1:0] grants_o,
  output logic [id_w-1:0]      grant_id_o,
  output logic                 v_o
);
  logic [id_w-1:0] last_q, last_d, idx;
  always_comb begin
    grant_id_o = '0;
    v_o = 1'b0;
    idx = '0;
    // scan lowest priority first so the highest-priority requester wins last
    for (int i = num_src_p; i >= 1; i--) begin
      idx = id_w'((int'(last_q) + i) % num_src_p);
      if (reqs_i[idx]) begin
        grant_id_o = idx;
        v_o = 1'b1;
      end
    end
    grants_o = v_o ? num_src_p'(1) << grant_id_o : '0;
    last_d = yumi_i && v_o ? grant_id_o : last_q;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) last_q <= id_w'(num_src_p - 1);
    else last_q <= last_d;
  end
endmodule

// File: rtl/bp_me_burst_arbiter.sv
// bp_me_burst_arbiter: merges num_src_p BedRock burst sources; a data message holds the output until its last beat
module bp_me_burst_arbiter
  import bp_me_burst_arbiter_pkg::*;
#(
  parameter int paddr_width_p = paddr_width_gp,
  parameter int data_width_p = 64,
  parameter int payload_width_p = 16,
  parameter int num_src_p = 2,
  localparam int bp_header_width_lp = bedrock_header_width(paddr_width_p, payload_width_p),
  localparam int lg_src_lp = safe_clog2(num_src_p)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_i,
  input  logic [num_src_p*bp_header_width_lp-1:0] in_msg_header_i,
  input  logic [num_src_p-1:0]                   in_msg_header_v_i,
  input  logic [num_src_p-1:0]                   in_msg_has_data_i,
  output logic [num_src_p-1:0]                   in_msg_header_ready_and_o,
  input  logic [num_src_p*data_width_p-1:0]      in_msg_data_i,
  input  logic [num_src_p-1:0]                   in_msg_data_v_i,
  input  logic [num_src_p-1:0]                   in_msg_last_i,
  output logic [num_src_p-1:0]                   in_msg_data_ready_and_o,
  output logic [bp_header_width_lp-1:0]          out_msg_header_o,
  output logic                                   out_msg_header_v_o,
  output logic                                   out_msg_has_data_o,
  input  logic                                   out_msg_header_ready_and_i,
  output logic [data_width_p-1:0]                out_msg_data_o,
  output logic                                   out_msg_data_v_o,
  output logic                                   out_msg_last_o,
  input  logic                                   out_msg_data_ready_and_i
);
  typedef enum logic {e_ready, e_data} bp_me_burst_arb_state_e;
  bp_me_burst_arb_state_e state_q, state_d;
  logic [lg_src_lp-1:0] lock_id_q, lock_id_d, grant_id;
  logic [num_src_p-1:0] grants;
  logic grant_v, ready_st, data_st, header_hs, data_hs;
  bp_me_burst_arbiter_rr #(.num_src_p(num_src_p)) rr (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .reqs_i(in_msg_header_v_i),
    .yumi_i(header_hs),
    .grants_o(grants),
    .grant_id_o(grant_id),
    .v_o(grant_v)
  );
  always_comb begin
    // reset gating keeps every valid and ready low while reset_i is high
    ready_st = state_q == e_ready && !reset_i;
    data_st = state_q == e_data && !reset_i;
    out_msg_header_o = in_msg_header_i[int'(grant_id)*bp_header_width_lp +: bp_header_width_lp];
    out_msg_has_data_o = in_msg_has_data_i[grant_id];
    out_msg_header_v_o = ready_st && grant_v;
    in_msg_header_ready_and_o = ready_st && out_msg_header_ready_and_i ? grants : '0;
    header_hs = out_msg_header_v_o && out_msg_header_ready_and_i;
    out_msg_data_o = in_msg_data_i[int'(lock_id_q)*data_width_p +: data_width_p];
    out_msg_last_o = in_msg_last_i[lock_id_q];
    out_msg_data_v_o = data_st && in_msg_data_v_i[lock_id_q];
    in_msg_data_ready_and_o = data_st && out_msg_data_ready_and_i ? num_src_p'(1) << lock_id_q : '0;
    data_hs = out_msg_data_v_o && out_msg_data_ready_and_i;
    lock_id_d = header_hs && out_msg_has_data_o ? grant_id : lock_id_q;
    state_d = header_hs && out_msg_has_data_o ? e_data
            : data_hs && out_msg_last_o ? e_ready
            : state_q;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_ready;
      lock_id_q <= '0;
    end else begin
      state_q <= state_d;
      lock_id_q <= lock_id_d;
    end
  end
endmodule
